// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU serial frame generator.
// Packets are 11 bits, sent MSB first: {start, kind, payload[7:0], stop}.
package alu_pkg;

  localparam int PKT_W = 11;
  typedef logic [PKT_W-1:0] packet_t;

  localparam logic PKT_DATA = 1'b0;
  localparam logic PKT_CMD  = 1'b1;

  localparam logic [3:0] CRC4_POLY = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CRC,
    ST_SEND_B,
    ST_SEND_A,
    ST_SEND_CMD
  } state_t;

  function automatic packet_t create_packet(input logic kind, input logic [7:0] payload);
    return {1'b0, kind, payload, 1'b1};
  endfunction

  // One step of the x^4+x+1 LFSR, message bit d shifted in MSB first.
  function automatic logic [3:0] crc4_step(input logic [3:0] c, input logic d);
    logic fb;
    fb = c[3] ^ d;
    return {c[2:0], 1'b0} ^ (fb ? CRC4_POLY : 4'b0000);
  endfunction

endpackage

// File: rtl/alu_crc4_lfsr.sv
// Bit-serial CRC-4 (x^4+x+1), cleared to zero, one message bit per enabled clock.
module alu_crc4_lfsr
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       shift_en,
  input  logic       d,
  output logic [3:0] crc
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      crc <= 4'b0000;
    end else if (shift_en) begin
      crc <= crc4_step(crc, d);
    end
  end

endmodule

// File: rtl/alu_frame_serializer.sv
// Serial frame generator: accepts one (A, B, op) request, computes its CRC-4
// bit-serially, then streams B bytes, A bytes and a command packet on sin.
module alu_frame_serializer
  import alu_pkg::*;
#(
  parameter int          OPERAND_W = 32,
  parameter logic [3:0]  CRC_FLIP  = 4'b0001,
  localparam int         NB        = OPERAND_W / 8,
  localparam int         DW        = $clog2(NB + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPERAND_W-1:0] in_a,
  input  logic [OPERAND_W-1:0] in_b,
  input  logic [2:0]           in_op,
  input  logic [DW-1:0]        in_drop_a,
  input  logic [DW-1:0]        in_drop_b,
  input  logic                 in_bad_crc,
  output logic                 sin,
  output logic                 busy,
  output logic                 done
);

  // Handshake: a request is taken on any rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE, so in_valid outside IDLE has no effect.

  localparam int             VW       = 2 * OPERAND_W + 4;
  localparam int             CW       = $clog2(VW);
  localparam logic [CW-1:0]  CRC_LAST = CW'(VW - 1);
  localparam logic [DW-1:0]  NB_D     = DW'(NB);

  function automatic logic [DW-1:0] keep_count(input logic [DW-1:0] drop);
    return (drop > NB_D) ? '0 : NB_D - drop;
  endfunction

  // Index 0 selects the most significant byte.
  function automatic logic [7:0] byte_sel(input logic [OPERAND_W-1:0] v,
                                          input logic [DW-1:0] idx);
    int lsb;
    lsb = 8 * (NB - 1 - int'(idx));
    return v[lsb +: 8];
  endfunction

  state_t               state, state_nxt;
  logic [OPERAND_W-1:0] a_r, b_r;
  logic [2:0]           op_r;
  logic                 bad_crc_r;
  logic [DW-1:0]        keep_a, keep_b;
  logic [CW-1:0]        crc_cnt;
  logic [DW-1:0]        byte_idx, byte_idx_nxt, idx_inc;
  logic [3:0]           bit_cnt;
  packet_t              shreg, load_pkt, cmd_pkt;
  logic                 load_en, done_nxt, done_r;
  logic                 accept, sending, pkt_end;
  logic [VW-1:0]        vec;
  logic                 crc_bit;
  logic [3:0]           crc, crc_final;

  assign accept  = (state == ST_IDLE) && in_valid;
  assign sending = (state == ST_SEND_B) || (state == ST_SEND_A) || (state == ST_SEND_CMD);
  assign pkt_end = (bit_cnt == 4'd10);
  assign idx_inc = byte_idx + DW'(1);
  assign vec     = {b_r, a_r, 1'b1, op_r};
  assign crc_bit = vec[CRC_LAST - crc_cnt];

  alu_crc4_lfsr u_crc (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .shift_en (state == ST_CRC),
    .d        (crc_bit),
    .crc      (crc)
  );

  // When no data packet is sent the command loads on the final CRC edge,
  // before the LFSR register has absorbed the last bit.
  assign crc_final = (state == ST_CRC) ? crc4_step(crc, crc_bit) : crc;
  assign cmd_pkt   = create_packet(PKT_CMD,
                       {1'b0, op_r, bad_crc_r ? (crc_final ^ CRC_FLIP) : crc_final});

  always_comb begin
    state_nxt    = state;
    byte_idx_nxt = byte_idx;
    load_en      = 1'b0;
    load_pkt     = '1;
    done_nxt     = 1'b0;
    case (state)
      ST_IDLE: if (in_valid) state_nxt = ST_CRC;
      ST_CRC: begin
        if (crc_cnt == CRC_LAST) begin
          load_en      = 1'b1;
          byte_idx_nxt = '0;
          if (keep_b != '0) begin
            state_nxt = ST_SEND_B;
            load_pkt  = create_packet(PKT_DATA, byte_sel(b_r, '0));
          end else if (keep_a != '0) begin
            state_nxt = ST_SEND_A;
            load_pkt  = create_packet(PKT_DATA, byte_sel(a_r, '0));
          end else begin
            state_nxt = ST_SEND_CMD;
            load_pkt  = cmd_pkt;
          end
        end
      end
      ST_SEND_B: begin
        if (pkt_end) begin
          load_en = 1'b1;
          if (idx_inc < keep_b) begin
            byte_idx_nxt = idx_inc;
            load_pkt     = create_packet(PKT_DATA, byte_sel(b_r, idx_inc));
          end else if (keep_a != '0) begin
            state_nxt    = ST_SEND_A;
            byte_idx_nxt = '0;
            load_pkt     = create_packet(PKT_DATA, byte_sel(a_r, '0));
          end else begin
            state_nxt = ST_SEND_CMD;
            load_pkt  = cmd_pkt;
          end
        end
      end
      ST_SEND_A: begin
        if (pkt_end) begin
          load_en = 1'b1;
          if (idx_inc < keep_a) begin
            byte_idx_nxt = idx_inc;
            load_pkt     = create_packet(PKT_DATA, byte_sel(a_r, idx_inc));
          end else begin
            state_nxt = ST_SEND_CMD;
            load_pkt  = cmd_pkt;
          end
        end
      end
      ST_SEND_CMD: begin
        if (pkt_end) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      a_r       <= '0;
      b_r       <= '0;
      op_r      <= '0;
      bad_crc_r <= 1'b0;
      keep_a    <= '0;
      keep_b    <= '0;
      crc_cnt   <= '0;
      byte_idx  <= '0;
      bit_cnt   <= '0;
      shreg     <= '1;
      done_r    <= 1'b0;
    end else begin
      state    <= state_nxt;
      byte_idx <= byte_idx_nxt;
      done_r   <= done_nxt;
      if (accept) begin
        a_r       <= in_a;
        b_r       <= in_b;
        op_r      <= in_op;
        bad_crc_r <= in_bad_crc;
        keep_a    <= keep_count(in_drop_a);
        keep_b    <= keep_count(in_drop_b);
        crc_cnt   <= '0;
      end else if (state == ST_CRC) begin
        crc_cnt <= crc_cnt + CW'(1);
      end
      if (load_en) begin
        shreg   <= load_pkt;
        bit_cnt <= '0;
      end else if (sending) begin
        if (pkt_end) begin
          bit_cnt <= '0;
        end else begin
          shreg   <= {shreg[PKT_W-2:0], 1'b1};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end
    end
  end

  assign sin      = sending ? shreg[PKT_W-1] : 1'b1;
  assign in_ready = (state == ST_IDLE);
  assign busy     = !in_ready;
  assign done     = done_r;

endmodule

// File: tb/tb_alu_frame_serializer.sv
// Directed bench for alu_frame_serializer: a frame-level reference model predicts
// {sin, busy, in_ready, done} for every cycle, plus hand-computed pins.
module tb_alu_frame_serializer;

  localparam int         OPERAND_W = 32;
  localparam logic [3:0] CRC_FLIP  = 4'b0001;
  localparam int         NB        = OPERAND_W / 8;
  localparam int         DW        = $clog2(NB + 1);
  localparam int         VW        = 2 * OPERAND_W + 4;
  localparam logic [3:0] EXP_IDLE  = 4'b1010;
  localparam logic [3:0] EXP_CRC   = 4'b1100;
  localparam logic [3:0] EXP_DONE  = 4'b1011;

  logic                 clk, rst, in_valid, in_ready, in_bad_crc;
  logic [OPERAND_W-1:0] in_a, in_b;
  logic [2:0]           in_op;
  logic [DW-1:0]        in_drop_a, in_drop_b;
  logic                 sin, busy, done;

  alu_frame_serializer #(.OPERAND_W(OPERAND_W), .CRC_FLIP(CRC_FLIP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .in_drop_a(in_drop_a), .in_drop_b(in_drop_b), .in_bad_crc(in_bad_crc),
    .sin(sin), .busy(busy), .done(done)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  int         acc_cnt = 0;
  int         done_cnt = 0;
  logic       chk_en = 1'b0;
  logic       cur_ready = 1'b0;
  logic [3:0] exp_q[$];

  // ---------------- reference model ----------------
  function automatic int sat(input logic [DW-1:0] d);
    return (int'(d) > NB) ? NB : int'(d);
  endfunction

  // CRC as the remainder of M(x)*x^4 divided by x^4+x+1.
  function automatic logic [3:0] model_crc(input logic [OPERAND_W-1:0] a,
                                           input logic [OPERAND_W-1:0] b,
                                           input logic [2:0] op);
    logic [VW-1:0] v;
    logic          m[VW+4];
    v = {b, a, 1'b1, op};
    for (int i = 0; i < VW; i++) m[i] = v[VW-1-i];
    for (int i = VW; i < VW + 4; i++) m[i] = 1'b0;
    for (int i = 0; i < VW; i++) begin
      if (m[i]) begin
        m[i]   = ~m[i];
        m[i+3] = ~m[i+3];
        m[i+4] = ~m[i+4];
      end
    end
    return {m[VW], m[VW+1], m[VW+2], m[VW+3]};
  endfunction

  function automatic int model_len(input logic [DW-1:0] da, input logic [DW-1:0] db);
    return 11 * (2 * NB - sat(da) - sat(db) + 1);
  endfunction

  // Bit i of the result is the i-th bit on the line.
  function automatic logic [255:0] model_frame(input logic [OPERAND_W-1:0] a,
                                               input logic [OPERAND_W-1:0] b,
                                               input logic [2:0] op,
                                               input logic [DW-1:0] da,
                                               input logic [DW-1:0] db,
                                               input logic bad);
    logic [255:0] f;
    logic [10:0]  pkt;
    logic [3:0]   c;
    int           n;
    f = '1;
    n = 0;
    for (int j = NB - 1; j >= sat(db); j--) begin
      pkt = {2'b00, b[8*j +: 8], 1'b1};
      for (int k = 10; k >= 0; k--) begin f[n] = pkt[k]; n++; end
    end
    for (int j = NB - 1; j >= sat(da); j--) begin
      pkt = {2'b00, a[8*j +: 8], 1'b1};
      for (int k = 10; k >= 0; k--) begin f[n] = pkt[k]; n++; end
    end
    c   = model_crc(a, b, op) ^ (bad ? CRC_FLIP : 4'b0000);
    pkt = {2'b01, 1'b0, op, c, 1'b1};
    for (int k = 10; k >= 0; k--) begin f[n] = pkt[k]; n++; end
    return f;
  endfunction

  function automatic logic [7:0] payload_at(input logic [255:0] f, input int p);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[7-k] = f[11*p + 2 + k];
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else if (chk_en && cur_ready && in_valid) begin
      logic [255:0] f;
      int           n;
      f = model_frame(in_a, in_b, in_op, in_drop_a, in_drop_b, in_bad_crc);
      n = model_len(in_drop_a, in_drop_b);
      for (int i = 0; i < VW; i++) exp_q.push_back(EXP_CRC);
      for (int i = 0; i < n; i++) exp_q.push_back({f[i], 3'b100});
      exp_q.push_back(EXP_DONE);
      acc_cnt++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [3:0] e;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : EXP_IDLE;
      cur_ready = e[1];
      vectors++;
      if ({sin, busy, in_ready, done} !== e) begin
        miscompares++;
        $display("FAIL line_state t=%0t got {sin,busy,ready,done}=%b want=%b",
                 $time, {sin, busy, in_ready, done}, e);
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic pin(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic start_req(input logic [OPERAND_W-1:0] a, input logic [OPERAND_W-1:0] b,
                           input logic [2:0] op, input int da, input int db, input logic bad);
    @(negedge clk);
    in_a       = a;
    in_b       = b;
    in_op      = op;
    in_drop_a  = DW'(da);
    in_drop_b  = DW'(db);
    in_bad_crc = bad;
    in_valid   = 1'b1;
  endtask

  task automatic wait_accept(input int target);
    int guard;
    guard = 0;
    while (acc_cnt < target && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (acc_cnt < target) pin("accept_timeout", 32'(acc_cnt), 32'(target));
  endtask

  task automatic send(input logic [OPERAND_W-1:0] a, input logic [OPERAND_W-1:0] b,
                      input logic [2:0] op, input int da, input int db, input logic bad);
    int target;
    target = acc_cnt + 1;
    start_req(a, b, op, da, db, bad);
    wait_accept(target);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) pin("idle_timeout", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [255:0] f;
    logic [7:0]   s3_pay[6];
    int           d0, t1;
    s3_pay = '{8'hAA, 8'hBB, 8'h11, 8'h22, 8'h33, 8'h44};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    in_drop_a = '0; in_drop_b = '0; in_bad_crc = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: all-zero operands, good CRC
    pin("s1_crc", 32'(model_crc('0, '0, 3'b000)), 32'hB);
    pin("s1_len", 32'(model_len('0, '0)), 32'd99);
    f = model_frame('0, '0, 3'b000, '0, '0, 1'b0);
    pin("s1_data0", 32'(payload_at(f, 0)), 32'h00);
    pin("s1_cmd_kind", 32'({f[88], f[89], f[98]}), 32'b011);
    pin("s1_cmd_pay", 32'(payload_at(f, 8)), 32'h0B);
    d0 = done_cnt;
    send('0, '0, 3'b000, 0, 0, 1'b0);
    wait_idle();
    pin("s1_done", 32'(done_cnt - d0), 32'd1);

    // 2: same with flipped CRC
    f = model_frame('0, '0, 3'b000, '0, '0, 1'b1);
    pin("s2_cmd_pay", 32'(payload_at(f, 8)), 32'h0A);
    d0 = done_cnt;
    send('0, '0, 3'b000, 0, 0, 1'b1);
    wait_idle();
    pin("s2_done", 32'(done_cnt - d0), 32'd1);

    // 3: partial drop of B
    f = model_frame(32'h11223344, 32'hAABBCCDD, 3'b001, DW'(0), DW'(2), 1'b0);
    for (int p = 0; p < 6; p++) pin("s3_payload", 32'(payload_at(f, p)), 32'(s3_pay[p]));
    pin("s3_len", 32'(model_len(DW'(0), DW'(2))), 32'd77);
    send(32'h11223344, 32'hAABBCCDD, 3'b001, 0, 2, 1'b0);
    wait_idle();

    // 4: saturating drops, only the command packet remains
    pin("s4_len", 32'(model_len(DW'(7), DW'(4))), 32'd11);
    f = model_frame('0, '0, 3'b000, DW'(7), DW'(4), 1'b0);
    pin("s4_cmd_pay", 32'(payload_at(f, 0)), 32'h0B);
    d0 = done_cnt;
    send('0, '0, 3'b000, 7, 4, 1'b0);
    wait_idle();
    pin("s4_done", 32'(done_cnt - d0), 32'd1);
    send(32'hDEADBEEF, 32'h0F1E2D3C, 3'b110, 5, 6, 1'b1);
    wait_idle();

    // 5: reset on the 5th bit of the second B packet
    d0 = done_cnt;
    send(32'hCAFEF00D, 32'h12345678, 3'b101, 0, 0, 1'b0);
    repeat (VW + 11 + 4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_idle();
    pin("s5_no_done", 32'(done_cnt - d0), 32'd0);
    send(32'h87654321, 32'h0BADC0DE, 3'b011, 1, 3, 1'b0);
    wait_idle();
    pin("s5_recover_done", 32'(done_cnt - d0), 32'd1);

    // 6: in_valid held across two requests
    d0 = done_cnt;
    t1 = acc_cnt + 1;
    start_req(32'h01020304, 32'hF0E0D0C0, 3'b111, 1, 0, 1'b0);
    wait_accept(t1);
    in_a = 32'h55AA55AA; in_b = 32'h33CC33CC; in_op = 3'b010;
    in_drop_a = DW'(0); in_drop_b = DW'(3); in_bad_crc = 1'b1;
    wait_accept(t1 + 1);
    in_valid = 1'b0;
    wait_idle();
    pin("s6_done", 32'(done_cnt - d0), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
